// File: rtl/apu_pkg.sv
// Shared APU register map: offsets, power state type, read-back OR-masks.
package apu_pkg;

    localparam logic [5:0] NR10_ADDR = 6'h10;
    localparam logic [5:0] NR11_ADDR = 6'h11;
    localparam logic [5:0] NR12_ADDR = 6'h12;
    localparam logic [5:0] NR13_ADDR = 6'h13;
    localparam logic [5:0] NR14_ADDR = 6'h14;
    localparam logic [5:0] NR21_ADDR = 6'h16;
    localparam logic [5:0] NR22_ADDR = 6'h17;
    localparam logic [5:0] NR23_ADDR = 6'h18;
    localparam logic [5:0] NR24_ADDR = 6'h19;
    localparam logic [5:0] NR30_ADDR = 6'h1A;
    localparam logic [5:0] NR31_ADDR = 6'h1B;
    localparam logic [5:0] NR32_ADDR = 6'h1C;
    localparam logic [5:0] NR33_ADDR = 6'h1D;
    localparam logic [5:0] NR34_ADDR = 6'h1E;
    localparam logic [5:0] NR41_ADDR = 6'h20;
    localparam logic [5:0] NR42_ADDR = 6'h21;
    localparam logic [5:0] NR43_ADDR = 6'h22;
    localparam logic [5:0] NR44_ADDR = 6'h23;
    localparam logic [5:0] NR50_ADDR = 6'h24;
    localparam logic [5:0] NR51_ADDR = 6'h25;
    localparam logic [5:0] NR52_ADDR = 6'h26;
    localparam logic [5:0] WAVE_BASE = 6'h30;

    localparam logic [5:0] SHADOW_LO = NR10_ADDR;
    localparam logic [5:0] SHADOW_HI = NR51_ADDR;

    typedef enum logic {
        PWR_OFF = 1'b0,
        PWR_ON  = 1'b1
    } pwr_state_t;

    // Bits that read back as 1 regardless of the stored value.
    function automatic logic [7:0] read_mask(input logic [5:0] addr);
        logic [7:0] m;
        case (addr)
            NR10_ADDR: m = 8'h80;
            NR11_ADDR: m = 8'h3F;
            NR12_ADDR: m = 8'h00;
            NR13_ADDR: m = 8'hFF;
            NR14_ADDR: m = 8'hBF;
            NR21_ADDR: m = 8'h3F;
            NR22_ADDR: m = 8'h00;
            NR23_ADDR: m = 8'hFF;
            NR24_ADDR: m = 8'hBF;
            NR30_ADDR: m = 8'h7F;
            NR31_ADDR: m = 8'hFF;
            NR32_ADDR: m = 8'h9F;
            NR33_ADDR: m = 8'hFF;
            NR34_ADDR: m = 8'hBF;
            NR41_ADDR: m = 8'hFF;
            NR42_ADDR: m = 8'h00;
            NR43_ADDR: m = 8'h00;
            NR44_ADDR: m = 8'hBF;
            NR50_ADDR: m = 8'h00;
            NR51_ADDR: m = 8'h00;
            NR52_ADDR: m = 8'h70;
            default:   m = (addr[5:4] == 2'b11) ? 8'h00 : 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/apu_wave_ram.sv
// 16x8 wave pattern RAM; while locked, all accesses are steered to the
// byte the channel is fetching.
module apu_wave_ram
    import apu_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [3:0] addr,
    input  logic       lock,
    input  logic [3:0] lock_addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);

    logic [7:0] mem [16];
    logic [3:0] eff_addr;

    assign eff_addr = lock ? lock_addr : addr;
    assign rdata    = mem[eff_addr];

    // Contents survive reset, like the real part.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[eff_addr] <= wdata;
        end
    end

endmodule

// File: rtl/apu_reg_readback.sv
// CPU read side of the APU: NR10-NR52 shadows, wave RAM and master power,
// returning registered read data with read-back OR-masks applied.
module apu_reg_readback
    import apu_pkg::*;
#(
    parameter bit WAVE_LOCK = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_we,
    input  logic       cpu_re,
    input  logic [5:0] reg_select,
    input  logic [7:0] cpu_wdata,
    input  logic [3:0] ch_active,
    input  logic [3:0] wave_pos,
    output logic [7:0] rdata,
    output logic       rvalid,
    output logic       apu_power
);

    pwr_state_t state, state_next;

    logic [7:0] shadow [SHADOW_LO:SHADOW_HI];
    logic       in_shadow;
    logic       is_nr52;
    logic       is_wave;
    logic       power_off;
    logic       wave_lock;
    logic       wave_we;
    logic [7:0] wave_rdata;
    logic [7:0] shadow_rd;
    logic [7:0] rd_next;

    assign in_shadow = (reg_select >= SHADOW_LO) && (reg_select <= SHADOW_HI);
    assign is_nr52   = (reg_select == NR52_ADDR);
    assign is_wave   = (reg_select[5:4] == WAVE_BASE[5:4]);
    assign apu_power = (state == PWR_ON);
    assign wave_lock = WAVE_LOCK && ch_active[2];
    assign wave_we   = cpu_we && is_wave;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= PWR_OFF;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        power_off  = 1'b0;
        if (cpu_we && is_nr52) begin
            state_next = cpu_wdata[7] ? PWR_ON : PWR_OFF;
        end
        if (state == PWR_ON && state_next == PWR_OFF) begin
            power_off = 1'b1;
        end
    end

    // A power-down write wipes the channel registers on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = int'(SHADOW_LO); i <= int'(SHADOW_HI); i++) begin
                shadow[i] <= 8'h00;
            end
        end else if (power_off) begin
            for (int i = int'(SHADOW_LO); i <= int'(SHADOW_HI); i++) begin
                shadow[i] <= 8'h00;
            end
        end else if (cpu_we && in_shadow && apu_power) begin
            shadow[reg_select] <= cpu_wdata;
        end
    end

    apu_wave_ram u_wave (
        .clk       (clk),
        .we        (wave_we),
        .addr      (reg_select[3:0]),
        .lock      (wave_lock),
        .lock_addr (wave_pos),
        .wdata     (cpu_wdata),
        .rdata     (wave_rdata)
    );

    always_comb begin
        shadow_rd = 8'h00;
        if (in_shadow) begin
            shadow_rd = shadow[reg_select];
        end
    end

    always_comb begin
        rd_next = 8'hFF;
        unique case (1'b1)
            in_shadow: rd_next = shadow_rd | read_mask(reg_select);
            is_nr52:   rd_next = {apu_power, 3'b111,
                                  apu_power ? ch_active : 4'h0};
            is_wave:   rd_next = wave_rdata;
            default:   rd_next = 8'hFF;
        endcase
    end

    // Read data is sampled before this edge's write takes effect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata  <= 8'h00;
            rvalid <= 1'b0;
        end else begin
            rvalid <= cpu_re;
            if (cpu_re) begin
                rdata <= rd_next;
            end
        end
    end

endmodule

// File: tb/tb_apu_reg_readback.sv
// Scoreboard bench for apu_reg_readback: directed cases plus random traffic
// checked against a register-map reference model.
module tb_apu_reg_readback;

    localparam bit LOCK = 1'b1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_we = 1'b0;
    logic       cpu_re = 1'b0;
    logic [5:0] reg_select = 6'h00;
    logic [7:0] cpu_wdata = 8'h00;
    logic [3:0] ch_active = 4'h0;
    logic [3:0] wave_pos = 4'h0;
    logic [7:0] rdata;
    logic       rvalid;
    logic       apu_power;

    int checks = 0;
    int passed = 0;

    logic [7:0] exp_q [$];
    logic [7:0] last_rd = 8'h00;
    bit         mon_en = 1'b0;

    logic [7:0] m_reg [64];
    logic [7:0] m_wave [16];
    bit         m_pw;
    logic [3:0] cfg_ch = 4'h0;
    logic [3:0] cfg_wp = 4'h0;

    always #5 clk = ~clk;

    apu_reg_readback #(.WAVE_LOCK(LOCK)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_we     (cpu_we),
        .cpu_re     (cpu_re),
        .reg_select (reg_select),
        .cpu_wdata  (cpu_wdata),
        .ch_active  (ch_active),
        .wave_pos   (wave_pos),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .apu_power  (apu_power)
    );

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %02h expected %02h at %0t",
                      name, act, exp, $time);
    endtask

    function automatic logic [7:0] mask_of(input logic [5:0] a);
        case (a)
            6'h10: return 8'h80;  6'h11: return 8'h3F;
            6'h12: return 8'h00;  6'h13: return 8'hFF;
            6'h14: return 8'hBF;  6'h16: return 8'h3F;
            6'h17: return 8'h00;  6'h18: return 8'hFF;
            6'h19: return 8'hBF;  6'h1A: return 8'h7F;
            6'h1B: return 8'hFF;  6'h1C: return 8'h9F;
            6'h1D: return 8'hFF;  6'h1E: return 8'hBF;
            6'h20: return 8'hFF;  6'h21: return 8'h00;
            6'h22: return 8'h00;  6'h23: return 8'hBF;
            6'h24: return 8'h00;  6'h25: return 8'h00;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [3:0] wave_idx(input logic [5:0] a);
        return (LOCK && cfg_ch[2]) ? cfg_wp : a[3:0];
    endfunction

    function automatic logic [7:0] model_read(input logic [5:0] a);
        if (a >= 6'h10 && a <= 6'h25) return m_reg[a] | mask_of(a);
        if (a == 6'h26) return {m_pw, 3'b111, m_pw ? cfg_ch : 4'h0};
        if (a >= 6'h30) return m_wave[wave_idx(a)];
        return 8'hFF;
    endfunction

    task automatic model_reset();
        m_pw = 1'b0;
        for (int i = 0; i < 64; i++) m_reg[i] = 8'h00;
    endtask

    task automatic model_write(input logic [5:0] a, input logic [7:0] d);
        if (a >= 6'h10 && a <= 6'h25) begin
            if (m_pw) m_reg[a] = d;
        end else if (a == 6'h26) begin
            if (m_pw && !d[7]) begin
                for (int i = 0; i < 64; i++) m_reg[i] = 8'h00;
            end
            m_pw = d[7];
        end else if (a >= 6'h30) begin
            m_wave[wave_idx(a)] = d;
        end
    endtask

    task automatic cycle(input bit we, input bit re, input logic [5:0] a,
                         input logic [7:0] d);
        @(negedge clk);
        #1;
        ch_active  = cfg_ch;
        wave_pos   = cfg_wp;
        cpu_we     = we;
        cpu_re     = re;
        reg_select = a;
        cpu_wdata  = d;
        if (re) exp_q.push_back(model_read(a));
        if (we) model_write(a, d);
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        cycle(1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [5:0] a);
        cycle(1'b0, 1'b1, a, 8'h00);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 6'h00, 8'h00);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_v;
            logic [7:0] e;
            exp_v = (exp_q.size() != 0);
            chk("rvalid", 8'(rvalid), 8'(exp_v));
            if (exp_v) begin
                e = exp_q.pop_front();
                if (rvalid) chk("rdata", rdata, e);
            end else if (!rvalid) begin
                chk("rdata_hold", rdata, last_rd);
            end
            last_rd = rdata;
            chk("apu_power", 8'(apu_power), 8'(m_pw));
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_rdata", rdata, 8'h00);
        chk("reset_rvalid", 8'(rvalid), 8'h00);
        chk("reset_power", 8'(apu_power), 8'h00);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;

        rd(6'h10);
        rd(6'h26);
        wr(6'h26, 8'h80);
        wr(6'h11, 8'hC5);
        rd(6'h11);
        wr(6'h12, 8'hA3);
        rd(6'h12);

        wr(6'h24, 8'h77);
        wr(6'h26, 8'h00);
        rd(6'h24);
        wr(6'h24, 8'h55);
        rd(6'h24);

        wr(6'h35, 8'h9A);
        rd(6'h35);
        cfg_ch = 4'b0100;
        cfg_wp = 4'd5;
        rd(6'h3C);
        cfg_ch = 4'h0;

        wr(6'h26, 8'h80);
        cfg_ch = 4'b1011;
        rd(6'h26);
        rd(6'h27);
        rd(6'h15);
        rd(6'h05);
        cfg_ch = 4'h0;

        wr(6'h13, 8'h34);
        cycle(1'b1, 1'b1, 6'h13, 8'h12);
        wr(6'h12, 8'h34);
        cycle(1'b1, 1'b1, 6'h12, 8'h12);
        rd(6'h12);

        wr(6'h11, 8'h40);
        rd(6'h11);
        wr(6'h26, 8'h00);
        rd(6'h11);
        idle();
        idle();

        rd(6'h10);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        model_reset();
        last_rd = 8'h00;
        #1;
        chk("midread_rvalid", 8'(rvalid), 8'h00);
        chk("midread_rdata", rdata, 8'h00);
        idle();
        reset = 1'b0;
        idle();
        rd(6'h35);

        cfg_ch = 4'h0;
        for (int i = 0; i < 16; i++) wr(6'h30 + 6'(i), 8'($urandom));
        wr(6'h26, 8'h80);
        for (int n = 0; n < 1500; n++) begin
            int r;
            logic [5:0] a;
            if (n % 8 == 0) begin
                cfg_ch = 4'($urandom);
                cfg_wp = 4'($urandom);
            end
            r = $urandom_range(0, 19);
            if (r < 12)      a = 6'h10 + 6'($urandom_range(0, 21));
            else if (r == 12) a = 6'h26;
            else if (r < 18) a = 6'h30 + 6'($urandom_range(0, 15));
            else             a = 6'($urandom);
            cycle(1'($urandom), 1'($urandom), a, 8'($urandom));
        end
        idle();
        idle();
        chk("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
